// File: rtl/rr_lock_arbiter_if.sv
// Request/grant bundle between REQS requesters and rr_lock_arbiter.
// RR_ARB_GRANT_CNT_EN adds the grant_cnt_o statistics counter.
interface rr_lock_arbiter_if #(
    parameter int unsigned REQS = 4
);
    localparam int unsigned ID_W = (REQS > 1) ? $clog2(REQS) : 1;

    logic [REQS-1:0] req_i;
    logic            done_i;
    logic [REQS-1:0] gnt_o;
    logic            gnt_valid_o;
    logic [ID_W-1:0] gnt_id_o;
`ifdef RR_ARB_GRANT_CNT_EN
    logic [15:0]     grant_cnt_o;

    modport master (
        output req_i, done_i,
        input  gnt_o, gnt_valid_o, gnt_id_o, grant_cnt_o
    );

    modport slave (
        input  req_i, done_i,
        output gnt_o, gnt_valid_o, gnt_id_o, grant_cnt_o
    );
`else
    modport master (
        output req_i, done_i,
        input  gnt_o, gnt_valid_o, gnt_id_o
    );

    modport slave (
        input  req_i, done_i,
        output gnt_o, gnt_valid_o, gnt_id_o
    );
`endif
endinterface

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant locking, release on done/withdrawal/hold limit.
// Optional macro RR_ARB_GRANT_CNT_EN enables a saturating count of issued grants.
module rr_lock_arbiter #(
    parameter int unsigned REQS     = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input logic              clk,
    input logic              reset,
    rr_lock_arbiter_if.slave bus
);
    localparam int unsigned ID_W   = (REQS > 1) ? $clog2(REQS) : 1;
    localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = (MAX_HOLD > 0) ? HOLD_W'(1) : '0;
    localparam logic [ID_W-1:0]   LAST_INIT = ID_W'(REQS - 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [REQS-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic              withdraw;
    logic              hold_hit;
    logic              release_hit;
    logic [ID_W-1:0]   sel_ptr;
    logic [REQS-1:0]   sel_cand;
    logic              win_found;
    logic [ID_W-1:0]   win_id;
    int unsigned       pos;
    logic              issue;

    always_comb begin
        withdraw    = ~bus.req_i[id_q];
        hold_hit    = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);
        release_hit = (state_q == StBusy) && (bus.done_i || withdraw || hold_hit);
        // On release the owner becomes the new pointer, so the search starts just after it.
        sel_ptr     = (state_q == StBusy) ? id_q : last_q;
        sel_cand    = bus.req_i;
        if ((state_q == StBusy) && withdraw) begin
            sel_cand[id_q] = 1'b0;
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        pos       = 0;
        for (int unsigned i = 0; i < REQS; i++) begin
            pos = 32'(sel_ptr) + 32'd1 + i;
            if (pos >= REQS) begin
                pos = pos - REQS;
            end
            if (!win_found && sel_cand[ID_W'(pos)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(pos);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        last_d  = last_q;
        hold_d  = hold_q;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    issue = 1'b1;
                end
            end
            StBusy: begin
                if (release_hit) begin
                    last_d = id_q;
                    if (win_found) begin
                        issue = 1'b1;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                        hold_d  = '0;
                    end
                end else if ((MAX_HOLD != 0) && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
        if (issue) begin
            state_d        = StBusy;
            gnt_d          = '0;
            gnt_d[win_id]  = 1'b1;
            id_d           = win_id;
            hold_d         = HOLD_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            id_q    <= '0;
            last_q  <= LAST_INIT;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

`ifdef RR_ARB_GRANT_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (issue && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.grant_cnt_o = cnt_q;
`endif

    assign bus.gnt_o       = gnt_q;
    assign bus.gnt_valid_o = |gnt_q;
    assign bus.gnt_id_o    = id_q;
endmodule
